alu_cmd_queue: RTL
==================

Name: alu_cmd_queue

Overview:
- Command queue and issue sequencer directly upstream of the registered ALU stage.
- Captures {operand A, function select} pairs from switch inputs on each push-key press, buffers up to DEPTH entries, and issues them to the ALU one at a time over a valid/ready handshake.
- Issue is either free-running (run=1) or single-stepped (step pulse), so a sequence of ALU operations can be loaded first and replayed against the ALU accumulator register.

Parameters:
DEPTH, 4, number of queue entries (power of two, >=2)
A_WIDTH, 4, operand A width
F_WIDTH, 3, function-select width
CNT_WIDTH, 3, width of count output (must hold 0..DEPTH)

Ports:
clock  input  1  single system clock, rising-edge
reset  input  1  asynchronous, active-high reset
push_key  input  1  raw push request (level, asynchronous to clock); each rising edge enqueues one command
sw_a  input  A_WIDTH  operand A captured on push
sw_func  input  F_WIDTH  function select captured on push
run  input  1  1 = auto-issue while non-empty; 0 = single-step mode
step  input  1  single-cycle pulse; requests one issue when run=0
issue_ready  input  1  downstream ALU stage accepts command this cycle
issue_valid  output  1  command on issue_a/issue_func is valid
issue_a  output  A_WIDTH  issued operand A
issue_func  output  F_WIDTH  issued function select
count  output  CNT_WIDTH  current occupancy
empty  output  1  count==0
full  output  1  count==DEPTH
overflow  output  1  sticky: a push was dropped
state  output  2  FSM state (IDLE=00, ISSUE=01, GAP=10)

Behaviour:
- Reset (async, active-high): immediately sets all outputs and state to reset values. issue_valid=0, issue_a=0, issue_func=0, count=0, empty=1, full=0, overflow=0, state=IDLE, step_pending=0, synchroniser flops=0, read/write pointers=0. Reset mid-handshake drops issue_valid without a transfer. Queue contents are discarded.
- Push path: push_key passes through a 2-flop synchroniser plus a delay flop. push_edge = sync2 & ~sync3.
- Enqueue happens on the 3rd rising edge that samples push_key high. sw_a/sw_func are sampled on that same edge. Holding the key high enqueues only once.
- Full with no pop in the same cycle: the push is dropped and overflow is set. overflow stays set until reset.
- Full with a pop in the same cycle: the push is accepted and count is unchanged.
- Pointers wrap modulo DEPTH. count, empty and full are registered and consistent in the same cycle.
- step: when run=0 and !empty, a step pulse sets step_pending. step is ignored when empty or when run=1. step_pending clears on entry to ISSUE.
- FSM:
  - IDLE -> ISSUE when !empty and (run or step_pending). On this transition, issue_a/issue_func load the head entry and issue_valid goes to 1.
  - ISSUE: issue_valid=1. issue_a/issue_func are held stable. issue_valid is never retracted until transfer, even if run falls.
  - Transfer = issue_valid & issue_ready at a rising edge. On transfer: the head is popped (count-1) and the FSM goes to GAP.
  - GAP: issue_valid=0 for exactly one cycle, so the ALU register settles.
  - GAP -> ISSUE when run=1 and !empty; the next head loads and is issued. Otherwise GAP -> IDLE.
  - issue_a/issue_func retain their last values outside ISSUE.
- Throughput: at most one command per 2 cycles. Latency from IDLE with run=1 and a non-empty queue to issue_valid is 1 cycle.
- Simultaneous push and pop on an empty-to-one transition cannot occur, because a pop requires a non-empty queue at the prior edge. A push into an empty queue while in IDLE is issued at the earliest on the edge after count becomes 1.
- Unused state encoding 11 recovers to IDLE on the next edge.

Test Plan:
- Reset then idle: assert reset mid-cycle -> all outputs go to reset values immediately. count=0, empty=1, state=00, issue_valid=0.
- Push latency and ordering: run=0; push {A=3,F=2}, {A=5,F=7}, {A=1,F=0} -> each count increment lands on the 3rd edge after the key is sampled high. count=3. Three step pulses with issue_ready=1 issue (3,2), (5,7), (1,0) in order, each valid for 1 cycle followed by GAP.
- Full/overflow: push 5 commands with DEPTH=4 and no issue -> full=1, count=4, overflow=1. The 5th entry is absent on drain: exactly 4 issues, then empty=1.
- Backpressure: run=1, 2 entries, issue_ready=0 for 5 cycles -> issue_valid stays 1 and issue_a/issue_func stay stable. Drop run during the stall -> valid is held. Raise ready -> one transfer, GAP, then IDLE; the second entry is not issued.
- Push while full with simultaneous pop: queue full, run=1, ready=1, push edge coincides with the transfer -> count stays 4, overflow stays 0, and the new entry is issued last.
- Reset mid-operation: in ISSUE with 3 entries, assert reset -> issue_valid=0 at once. After release, count=0 and no issues occur with run=1.

Source files
------------

// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: command queue and issue sequencer feeding the registered ALU stage.
//
// Each rising edge of the push key captures one {operand A, function select} pair
// from the switches into a DEPTH-entry queue. Queued commands go to the ALU one at a
// time over a valid/ready handshake. Issue runs freely while run=1 and advances one
// command per step pulse while run=0. Every transfer is followed by one idle (GAP)
// cycle so the ALU accumulator register can settle.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-high reset
//   push_key     raw push request, asynchronous level; each rising edge enqueues once
//   sw_a         operand A captured on push
//   sw_func      function select captured on push
//   run          1: auto-issue while non-empty, 0: single-step mode
//   step         one-cycle pulse requesting a single issue when run=0
//   issue_ready  downstream ALU stage accepts the command this cycle
//   issue_valid  issue_a/issue_func carry a valid command
//   issue_a      issued operand A
//   issue_func   issued function select
//   count        current queue occupancy
//   empty        count == 0
//   full         count == DEPTH
//   overflow     sticky: a push was dropped because the queue was full
//   state        FSM state (IDLE=00, ISSUE=01, GAP=10)
module alu_cmd_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned A_WIDTH   = 4,
  parameter int unsigned F_WIDTH   = 3,
  parameter int unsigned CNT_WIDTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push_key,
  input  logic [A_WIDTH-1:0]   sw_a,
  input  logic [F_WIDTH-1:0]   sw_func,
  input  logic                 run,
  input  logic                 step,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic [A_WIDTH-1:0]   issue_a,
  output logic [F_WIDTH-1:0]   issue_func,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 empty,
  output logic                 full,
  output logic                 overflow,
  output logic [1:0]           state
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned EntW = A_WIDTH + F_WIDTH;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StGap   = 2'b10
  } state_e;

  // Push synchroniser: sync1/sync2 resolve metastability, sync3 delays for edge detect.
  logic sync1_q, sync2_q, sync3_q;
  logic push_edge;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= push_key;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign push_edge = sync2_q & ~sync3_q;

  // Queue storage and occupancy
  logic [EntW-1:0]      mem_q [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 empty_q, full_q, overflow_q;
  logic                 issue_valid_q;
  logic                 push_ok, pop, push_drop;
  logic [EntW-1:0]      head;

  assign pop       = issue_valid_q & issue_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign push_ok   = push_edge & (~full_q | pop);
  assign push_drop = push_edge & full_q & ~pop;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CNT_WIDTH'(1);
    end else if (!push_ok && pop) begin
      count_d = count_q - CNT_WIDTH'(1);
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  // When full with a pop, wr_ptr equals rd_ptr; the head is already held in
  // issue_a/issue_func, so overwriting it here is safe.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= {sw_a, sw_func};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CNT_WIDTH'(DEPTH));
      if (push_drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Issue sequencer
  state_e             state_q;
  logic               step_pending_q;
  logic [A_WIDTH-1:0] issue_a_q;
  logic [F_WIDTH-1:0] issue_func_q;
  logic               load_head;

  // Entry into ISSUE: from IDLE on run or a pending step, from GAP only on run.
  assign load_head = !empty_q &&
                     (((state_q == StIdle) && (run || step_pending_q)) ||
                      ((state_q == StGap) && run));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= StIdle;
      issue_valid_q  <= 1'b0;
      issue_a_q      <= '0;
      issue_func_q   <= '0;
      step_pending_q <= 1'b0;
    end else begin
      if (load_head) begin
        step_pending_q <= 1'b0;
      end else if (step && !run && !empty_q) begin
        step_pending_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (load_head) begin
            state_q       <= StIssue;
            issue_valid_q <= 1'b1;
            issue_a_q     <= head[EntW-1:F_WIDTH];
            issue_func_q  <= head[F_WIDTH-1:0];
          end
        end
        StIssue: begin
          // Valid is held until transfer, regardless of run.
          if (issue_ready) begin
            state_q       <= StGap;
            issue_valid_q <= 1'b0;
          end
        end
        StGap: begin
          if (load_head) begin
            state_q       <= StIssue;
            issue_valid_q <= 1'b1;
            issue_a_q     <= head[EntW-1:F_WIDTH];
            issue_func_q  <= head[F_WIDTH-1:0];
          end else begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q       <= StIdle;
          issue_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_a     = issue_a_q;
  assign issue_func  = issue_func_q;
  assign count       = count_q;
  assign empty       = empty_q;
  assign full        = full_q;
  assign overflow    = overflow_q;
  assign state       = state_q;

endmodule
